// File: rtl/blue_alu_core.sv
// blue_alu_core: A/B accumulator ALU with ZNC flags, iterative shift and multiply.
// Define BLUE_MUL_EN to build the shift-and-add multiplier (opcode 11); otherwise opcode 11 is illegal.
module blue_alu_core #(
  parameter int WIDTH = 16,
  parameter int SHW = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] imm,
  output logic [WIDTH-1:0] A_out,
  output logic [WIDTH-1:0] B_out,
  output logic [2:0]       znc_out,
  output logic             done,
  output logic             illegal
);
  localparam int CW = $clog2(WIDTH) + 1;
  typedef enum logic [1:0] {
    IDLE,
    SHIFT
`ifdef BLUE_MUL_EN
    , MUL
`endif
  } state_t;
  state_t state;
  logic [CW-1:0] cnt, amt;
  logic [WIDTH-1:0] sr, sh_src, res;
  logic sdir, sh_dir, res_c, wr_a, wr_f, ill, go_sh, go_mul;
  logic [WIDTH:0] sh_nx, sum, dif;
`ifdef BLUE_MUL_EN
  logic [2*WIDTH-1:0] prod, mul_src, mul_nx;
  logic [WIDTH:0] mul_hi;
  // Right-shifting product: multiplier bits leave the low half as partial sums fill the high half
  always_comb begin
    mul_src = state == MUL ? prod : {{WIDTH{1'b0}}, B_out};
    mul_hi = {1'b0, mul_src[2*WIDTH-1:WIDTH]} + (mul_src[0] ? {1'b0, A_out} : '0);
    mul_nx = {mul_hi, mul_src[WIDTH-1:1]};
  end
`endif
  assign op_ready = en && state == IDLE;
  always_comb begin
    sh_src = state == SHIFT ? sr : A_out;
    sh_dir = state == SHIFT ? sdir : op[1];
    sh_nx = sh_dir ? {sh_src[0], 1'b0, sh_src[WIDTH-1:1]} : {sh_src, 1'b0};
    amt = 32'(imm[SHW-1:0]) > 32'(WIDTH) ? CW'(WIDTH) : CW'(imm[SHW-1:0]);
    sum = {1'b0, A_out} + {1'b0, B_out};
    dif = {1'b0, A_out} - {1'b0, B_out};
    res = A_out;
    res_c = 1'b0;
    wr_a = 1'b0;
    ill = 1'b0;
    go_sh = 1'b0;
    go_mul = 1'b0;
    case (op)
      4'd0, 4'd7: ;
      4'd1: begin {res_c, res} = sum; wr_a = 1'b1; end
      4'd2: begin {res_c, res} = dif; wr_a = 1'b1; end
      4'd3: begin res = A_out & B_out; wr_a = 1'b1; end
      4'd4: begin res = A_out | B_out; wr_a = 1'b1; end
      4'd5: begin res = A_out ^ B_out; wr_a = 1'b1; end
      4'd6: begin res = imm; wr_a = 1'b1; end
      4'd8: begin res = B_out; wr_a = 1'b1; end
      4'd9, 4'd10:
        if (amt >= CW'(2)) go_sh = 1'b1;
        else begin
          {res_c, res} = amt == '0 ? {1'b0, A_out} : sh_nx;
          wr_a = 1'b1;
        end
`ifdef BLUE_MUL_EN
      4'd11: go_mul = 1'b1;
`endif
      4'd12: {res_c, res} = dif;
      default: ill = 1'b1;
    endcase
    wr_f = wr_a || op == 4'd12;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      A_out <= '0;
      B_out <= '0;
      znc_out <= '0;
      cnt <= '0;
      sr <= '0;
      sdir <= 1'b0;
      done <= 1'b0;
      illegal <= 1'b0;
`ifdef BLUE_MUL_EN
      prod <= '0;
`endif
    end else begin
      done <= 1'b0;
      illegal <= 1'b0;
      if (en)
        case (state)
          IDLE:
            if (op_valid) begin
              if (wr_a) A_out <= res;
              if (wr_f) znc_out <= {res == '0, res[WIDTH-1], res_c};
              if (op == 4'd7) B_out <= imm;
              if (op == 4'd8) B_out <= A_out;
              done <= !(go_sh || go_mul);
              illegal <= ill;
              if (go_sh) begin
                state <= SHIFT;
                sr <= sh_nx[WIDTH-1:0];
                sdir <= op[1];
                cnt <= amt - CW'(1);
              end
`ifdef BLUE_MUL_EN
              if (go_mul) begin
                state <= MUL;
                prod <= mul_nx;
                cnt <= CW'(WIDTH - 1);
              end
`endif
            end
          SHIFT:
            if (cnt == CW'(1)) begin
              A_out <= sh_nx[WIDTH-1:0];
              znc_out <= {sh_nx[WIDTH-1:0] == '0, sh_nx[WIDTH-1], sh_nx[WIDTH]};
              done <= 1'b1;
              state <= IDLE;
            end else begin
              sr <= sh_nx[WIDTH-1:0];
              cnt <= cnt - CW'(1);
            end
`ifdef BLUE_MUL_EN
          MUL:
            if (cnt == CW'(1)) begin
              A_out <= mul_nx[WIDTH-1:0];
              znc_out <= {mul_nx[WIDTH-1:0] == '0, mul_nx[WIDTH-1], |mul_nx[2*WIDTH-1:WIDTH]};
              done <= 1'b1;
              state <= IDLE;
            end else begin
              prod <= mul_nx;
              cnt <= cnt - CW'(1);
            end
`endif
          default: state <= IDLE;
        endcase
    end
endmodule

// File: tb/tb_blue_alu_core.sv
// tb_blue_alu_core: directed vectors with a scoreboard queue; a monitor checks every done pulse.
module tb_blue_alu_core;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b1;
  logic op_valid = 1'b0;
  logic op_ready;
  logic [3:0] op = '0;
  logic [15:0] imm = '0;
  logic [15:0] A_out, B_out;
  logic [2:0] znc_out;
  logic done, illegal;
  int cyc = 0;
  int nvec = 0;
  int nerr = 0;
  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [2:0]  znc;
    logic        ill;
    int          cyc;
  } exp_t;
  exp_t sbq[$];

  blue_alu_core dut (
    .clk(clk), .rst_n(rst_n), .en(en), .op_valid(op_valid), .op_ready(op_ready),
    .op(op), .imm(imm), .A_out(A_out), .B_out(B_out), .znc_out(znc_out),
    .done(done), .illegal(illegal)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    nvec++;
    if (act !== req) begin
      nerr++;
      $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", nm, act, req, cyc);
    end
  endfunction

  // Monitor: every done pulse pops one expected commit.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && illegal && !done) chk("illegal_without_done", 32'(illegal), 32'd0);
    if (rst_n && done) begin
      if (sbq.size() == 0) begin
        nvec++;
        nerr++;
        $display("FAIL unexpected_done: actual=1 required=0 (cycle %0d, A=%0h)", cyc, A_out);
      end else begin
        e = sbq.pop_front();
        chk("A_out", 32'(A_out), 32'(e.a));
        chk("B_out", 32'(B_out), 32'(e.b));
        chk("znc_out", 32'(znc_out), 32'(e.znc));
        chk("illegal", 32'(illegal), 32'(e.ill));
        chk("done_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  // lat 0 means the instruction is expected never to commit.
  task automatic issue(input logic [3:0] o, input logic [15:0] im, input logic [15:0] ea,
                       input logic [15:0] eb, input logic [2:0] ez, input logic ei, input int lat);
    exp_t e;
    int n = 0;
    while (!op_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("ready_wait", 32'(op_ready), 32'd1);
    op_valid = 1'b1;
    op = o;
    imm = im;
    if (lat > 0) begin
      e.a = ea;
      e.b = eb;
      e.znc = ez;
      e.ill = ei;
      e.cyc = cyc + lat;
      sbq.push_back(e);
    end
    @(negedge clk);
    op_valid = 1'b0;
  endtask

  task automatic stall_run(input logic [3:0] o, input logic [15:0] im, input logic [15:0] ea,
                           input logic [15:0] eb, input logic [2:0] ez, input int lat);
    issue(o, im, ea, eb, ez, 1'b0, lat + 5);
    repeat (2) @(negedge clk);
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1 chk("ready_en_low", 32'(op_ready), 32'd0);
      @(negedge clk);
    end
    en = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_A", 32'(A_out), 32'd0);
    chk("rst_B", 32'(B_out), 32'd0);
    chk("rst_znc", 32'(znc_out), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_illegal", 32'(illegal), 32'd0);
    chk("rst_ready", 32'(op_ready), 32'd1);
    issue(4'd6, 16'h7FFF, 16'h7FFF, 16'h0000, 3'b000, 1'b0, 1);
    issue(4'd7, 16'h0001, 16'h7FFF, 16'h0001, 3'b000, 1'b0, 1);
    issue(4'd1, 16'h0000, 16'h8000, 16'h0001, 3'b010, 1'b0, 1);
    issue(4'd6, 16'hFFFF, 16'hFFFF, 16'h0001, 3'b010, 1'b0, 1);
    issue(4'd1, 16'h0000, 16'h0000, 16'h0001, 3'b101, 1'b0, 1);
    issue(4'd6, 16'h0005, 16'h0005, 16'h0001, 3'b000, 1'b0, 1);
    issue(4'd7, 16'h0009, 16'h0005, 16'h0009, 3'b000, 1'b0, 1);
    issue(4'd12, 16'h0000, 16'h0005, 16'h0009, 3'b011, 1'b0, 1);
    issue(4'd2, 16'h0000, 16'hFFFC, 16'h0009, 3'b011, 1'b0, 1);
    issue(4'd3, 16'h0000, 16'h0008, 16'h0009, 3'b000, 1'b0, 1);
    issue(4'd4, 16'h0000, 16'h0009, 16'h0009, 3'b000, 1'b0, 1);
    issue(4'd5, 16'h0000, 16'h0000, 16'h0009, 3'b100, 1'b0, 1);
    issue(4'd8, 16'h0000, 16'h0009, 16'h0000, 3'b000, 1'b0, 1);
    issue(4'd0, 16'h0000, 16'h0009, 16'h0000, 3'b000, 1'b0, 1);
    issue(4'd6, 16'h8001, 16'h8001, 16'h0000, 3'b010, 1'b0, 1);
    issue(4'd9, 16'h0003, 16'h0008, 16'h0000, 3'b000, 1'b0, 3);
    chk("shl3_busy1", 32'(op_ready), 32'd0);
    op_valid = 1'b1;
    op = 4'd6;
    imm = 16'hFFFF;
    @(negedge clk);
    chk("shl3_busy2", 32'(op_ready), 32'd0);
    @(negedge clk);
    chk("shl3_ready", 32'(op_ready), 32'd1);
    op_valid = 1'b0;
    issue(4'd10, 16'h0000, 16'h0008, 16'h0000, 3'b000, 1'b0, 1);
    issue(4'd10, 16'd20, 16'h0000, 16'h0000, 3'b100, 1'b0, 16);
    issue(4'd6, 16'hC000, 16'hC000, 16'h0000, 3'b010, 1'b0, 1);
    issue(4'd9, 16'h0001, 16'h8000, 16'h0000, 3'b011, 1'b0, 1);
    issue(4'd6, 16'h0001, 16'h0001, 16'h0000, 3'b000, 1'b0, 1);
    issue(4'd9, 16'd16, 16'h0000, 16'h0000, 3'b101, 1'b0, 16);
    issue(4'd6, 16'h0006, 16'h0006, 16'h0000, 3'b000, 1'b0, 1);
    issue(4'd10, 16'h0002, 16'h0001, 16'h0000, 3'b001, 1'b0, 2);
    issue(4'd6, 16'h0123, 16'h0123, 16'h0000, 3'b000, 1'b0, 1);
    issue(4'd7, 16'h0100, 16'h0123, 16'h0100, 3'b000, 1'b0, 1);
`ifdef BLUE_MUL_EN
    issue(4'd11, 16'h0000, 16'h2300, 16'h0100, 3'b001, 1'b0, 16);
    issue(4'd6, 16'h0123, 16'h0123, 16'h0100, 3'b000, 1'b0, 1);
    stall_run(4'd11, 16'h0000, 16'h2300, 16'h0100, 3'b001, 16);
`else
    issue(4'd11, 16'h0000, 16'h0123, 16'h0100, 3'b000, 1'b1, 1);
    issue(4'd6, 16'h0001, 16'h0001, 16'h0100, 3'b000, 1'b0, 1);
    stall_run(4'd9, 16'd16, 16'h0000, 16'h0100, 3'b101, 16);
`endif
    issue(4'd6, 16'h00FF, 16'h00FF, 16'h0100, 3'b000, 1'b0, 1);
    issue(4'd9, 16'd10, 16'h0000, 16'h0000, 3'b000, 1'b0, 0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_A", 32'(A_out), 32'd0);
    chk("mid_rst_B", 32'(B_out), 32'd0);
    chk("mid_rst_znc", 32'(znc_out), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    chk("mid_rst_illegal", 32'(illegal), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("post_rst_ready", 32'(op_ready), 32'd1);
    repeat (12) @(negedge clk);
    chk("post_rst_A_held", 32'(A_out), 32'd0);
    issue(4'd6, 16'h1234, 16'h1234, 16'h0000, 3'b000, 1'b0, 1);
    issue(4'd7, 16'hABCD, 16'h1234, 16'hABCD, 3'b000, 1'b0, 1);
    issue(4'd12, 16'h0000, 16'h1234, 16'hABCD, 3'b001, 1'b0, 1);
    issue(4'd14, 16'h5555, 16'h1234, 16'hABCD, 3'b001, 1'b1, 1);
    issue(4'd15, 16'h5555, 16'h1234, 16'hABCD, 3'b001, 1'b1, 1);
    issue(4'd13, 16'h5555, 16'h1234, 16'hABCD, 3'b001, 1'b1, 1);
    issue(4'd7, 16'h0001, 16'h1234, 16'h0001, 3'b001, 1'b0, 1);
    issue(4'd0, 16'h0000, 16'h1234, 16'h0001, 3'b001, 1'b0, 1);
    issue(4'd6, 16'h0F0F, 16'h0F0F, 16'h0001, 3'b000, 1'b0, 1);
    issue(4'd7, 16'h00F1, 16'h0F0F, 16'h00F1, 3'b000, 1'b0, 1);
    issue(4'd1, 16'h0000, 16'h1000, 16'h00F1, 3'b000, 1'b0, 1);
    for (int i = 0; i < 100 && sbq.size() > 0; i++) @(negedge clk);
    chk("scoreboard_drained", 32'(sbq.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
